button_tx_arbiter: RTL and testbench

BUTTON_TX_ARBITER -- requirements
Module: button_tx_arbiter

---
 rtl/button_tx_if.sv | 30 +++
 rtl/button_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_button_tx_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/button_tx_if.sv
// Button-to-UART arbiter bus.
// Groups the requester side (req_pulse, req_data), the UART transmitter
// handshake (tx_busy, tx_start, tx_data) and the arbiter status outputs
// (grant, pending, done, timeout).
//   master : the arbiter (drives tx_start/tx_data/grant/pending/done/timeout)
//   slave  : the surrounding logic (drives req_pulse/req_data/tx_busy)
interface button_tx_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_pulse;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    tx_busy;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        pending;
    logic                    done;
    logic                    timeout;

    modport master (
        input  req_pulse, req_data, tx_busy,
        output tx_start, tx_data, grant, pending, done, timeout
    );

    modport slave (
        output req_pulse, req_data, tx_busy,
        input  tx_start, tx_data, grant, pending, done, timeout
    );
endinterface

// File: rtl/button_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ
// debounced buttons. Each button pulse latches a pending request; the
// arbiter picks the next pending requester after the last one served,
// strobes tx_start with that requester's byte and follows tx_busy until the
// frame completes (done) or the transmitter never answers (timeout, the
// request is put back for a retry).
// Ports:
//   clk    : clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : button_tx_if.master (requests in, transmitter handshake and
//            status out; all outputs come straight from registers)
module button_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    button_tx_if.master   bus
);
    localparam int                IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [7:0]        TMO_LIM  = 8'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              state_r,       state_s;
    logic [N_REQ-1:0]    pending_r,     pending_s;
    logic [N_REQ-1:0]    grant_r,       grant_s;
    logic [DATA_W-1:0]   tx_data_r,     tx_data_s;
    logic                tx_start_r,    tx_start_s;
    logic                done_r,        done_s;
    logic                timeout_r,     timeout_s;
    logic [7:0]          cnt_r,         cnt_s;
    logic [IDX_W-1:0]    last_winner_r, last_winner_s;
    logic [IDX_W-1:0]    owner_r,       owner_s;

    logic                win_found_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic [DATA_W-1:0]   win_data_s;
    logic [N_REQ-1:0]    win_onehot_s;

    // Round-robin search: first pending requester after last_winner, wrapping.
    always_comb begin
        int cand_v;
        cand_v       = 0;
        win_found_s  = 1'b0;
        win_idx_s    = {IDX_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            cand_v = (int'(last_winner_r) + k) % N_REQ;
            if (!win_found_s && pending_r[cand_v[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_v[IDX_W-1:0];
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Winner byte and one-hot grant pattern.
    always_comb begin
        win_data_s   = {DATA_W{1'b0}};
        win_onehot_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx_s == i[IDX_W-1:0]) begin
                win_data_s      = bus.req_data[i*DATA_W +: DATA_W];
                win_onehot_s[i] = 1'b1;
            end else begin
                win_onehot_s[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic; grant/tx_data hold by default so they
    // stay stable until the done/timeout cycle has been seen.
    always_comb begin
        state_s       = state_r;
        pending_s     = pending_r | bus.req_pulse;
        grant_s       = grant_r;
        tx_data_s     = tx_data_r;
        tx_start_s    = 1'b0;
        done_s        = 1'b0;
        timeout_s     = 1'b0;
        cnt_s         = cnt_r;
        last_winner_s = last_winner_r;
        owner_s       = owner_r;
        case (state_r)
            ST_IDLE: begin
                grant_s = {N_REQ{1'b0}};
                if (win_found_s && !bus.tx_busy) begin
                    grant_s   = win_onehot_s;
                    tx_data_s = win_data_s;
                    owner_s   = win_idx_s;
                    // A re-press on the grant edge keeps the request pending.
                    pending_s[win_idx_s] = bus.req_pulse[win_idx_s];
                    tx_start_s = 1'b1;
                    state_s    = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_s   = 8'd0;
                state_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                cnt_s = cnt_r + 8'd1;
                if (bus.tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else if ((cnt_r + 8'd1) == TMO_LIM) begin
                    // Transmitter never answered: put the request back.
                    timeout_s          = 1'b1;
                    pending_s[owner_r] = 1'b1;
                    last_winner_s      = owner_r;
                    state_s            = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    done_s        = 1'b1;
                    last_winner_s = owner_r;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: begin
                grant_s = {N_REQ{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pending_r     <= {N_REQ{1'b0}};
            grant_r       <= {N_REQ{1'b0}};
            tx_data_r     <= {DATA_W{1'b0}};
            tx_start_r    <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
            cnt_r         <= 8'd0;
            last_winner_r <= LAST_RST;
            owner_r       <= {IDX_W{1'b0}};
        end else begin
            state_r       <= state_s;
            pending_r     <= pending_s;
            grant_r       <= grant_s;
            tx_data_r     <= tx_data_s;
            tx_start_r    <= tx_start_s;
            done_r        <= done_s;
            timeout_r     <= timeout_s;
            cnt_r         <= cnt_s;
            last_winner_r <= last_winner_s;
            owner_r       <= owner_s;
        end
    end

    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.grant    = grant_r;
    assign bus.pending  = pending_r;
    assign bus.done     = done_r;
    assign bus.timeout  = timeout_r;
endmodule

// File: tb/tb_button_tx_arbiter.sv
// Self-checking bench for button_tx_arbiter: directed scenarios followed by
// random button traffic, every cycle compared against a transaction-level
// reference model (pending set, round-robin pick, transfer timeline measured
// in cycles since tx_start) plus a UART stub that answers tx_start.
module tb_button_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    button_tx_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    button_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [N-1:0]  m_pend, m_grant;
    logic [DW-1:0] m_data;
    logic          m_start, m_done, m_tmo;
    int            m_last, m_own, m_since;
    bit            m_fin, m_busy_seen;

    // UART stub
    int stub_wait, stub_len, stub_fix_d, stub_fix_len;
    bit stub_off;

    logic [N-1:0] seen_grants[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_grant = '0; m_data = '0;
        m_start = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
        m_last = N - 1; m_own = -1; m_since = 0;
        m_fin = 1'b0; m_busy_seen = 1'b0;
        stub_wait = -1; stub_len = 0;
    endtask

    task automatic model_step(input logic [N-1:0] rp, input logic [N*DW-1:0] rd, input logic busy);
        logic [N-1:0] p;
        int w;
        p = m_pend;
        m_pend  = m_pend | rp;
        m_start = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
        if (m_own < 0 || m_fin) begin
            m_fin = 1'b0; m_own = -1; m_grant = '0;
            if (p != '0 && !busy) begin
                w = rr_pick(p, m_last);
                m_own = w; m_grant[w] = 1'b1;
                m_data = rd[w*DW +: DW];
                m_pend[w] = rp[w];
                m_start = 1'b1; m_since = 0; m_busy_seen = 1'b0;
            end
        end else begin
            m_since++;
            if (m_since >= 2) begin
                if (!m_busy_seen) begin
                    if (busy) m_busy_seen = 1'b1;
                    else if (m_since == T + 1) begin
                        m_tmo = 1'b1; m_pend[m_own] = 1'b1; m_last = m_own; m_fin = 1'b1;
                    end
                end else if (!busy) begin
                    m_done = 1'b1; m_last = m_own; m_fin = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("tx_start", 32'(bus.tx_start), 32'(m_start));
        check_eq("tx_data",  32'(bus.tx_data),  32'(m_data));
        check_eq("grant",    32'(bus.grant),    32'(m_grant));
        check_eq("pending",  32'(bus.pending),  32'(m_pend));
        check_eq("done",     32'(bus.done),     32'(m_done));
        check_eq("timeout",  32'(bus.timeout),  32'(m_tmo));
    endtask

    // One clock cycle: drive at negedge, model at posedge, check at negedge.
    task automatic tick(input logic [N-1:0] rp, input logic [N*DW-1:0] rd);
        bus.req_pulse = rp;
        bus.req_data  = rd;
        if (stub_wait > 0) begin
            bus.tx_busy = 1'b0; stub_wait--;
        end else if (stub_wait == 0 && stub_len > 0) begin
            bus.tx_busy = 1'b1; stub_len--;
        end else begin
            bus.tx_busy = 1'b0; stub_wait = -1;
        end
        @(posedge clk);
        if (rst_n) model_step(rp, rd, bus.tx_busy);
        @(negedge clk);
        check_outputs();
        if (bus.tx_start === 1'b1) seen_grants.push_back(bus.grant);
        if (m_start && !stub_off) begin
            stub_wait = (stub_fix_d >= 0) ? stub_fix_d : $urandom_range(0, T + 1);
            stub_len  = (stub_fix_len > 0) ? stub_fix_len : $urandom_range(1, 6);
        end
    endtask

    // Asynchronous reset pulse between clock edges, outputs checked before any edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.req_pulse = '0;
        bus.tx_busy   = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        seen_grants.delete();
    endtask

    task automatic idle_ticks(input int n, input logic [N*DW-1:0] rd);
        for (int i = 0; i < n; i++) tick('0, rd);
    endtask

    localparam logic [N*DW-1:0] BYTES = 32'h44434241;

    initial begin
        logic [N-1:0] e;
        n_checks = 0; n_errors = 0;
        stub_fix_d = -1; stub_fix_len = 0; stub_off = 1'b0;
        rst_n = 1'b0;
        bus.req_pulse = '0; bus.req_data = '0; bus.tx_busy = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // single request, busy 2 cycles after start for 10 cycles
        stub_fix_d = 2; stub_fix_len = 10;
        tick(4'b0100, BYTES);
        idle_ticks(20, BYTES);
        check_eq("single_count", 32'(seen_grants.size()), 32'd1);
        check_eq("single_grant", 32'((seen_grants.size() > 0) ? seen_grants[0] : 4'h0), 32'h4);

        // all four at once after reset
        do_reset();
        stub_fix_d = 1; stub_fix_len = 3;
        tick(4'b1111, BYTES);
        idle_ticks(50, BYTES);
        check_eq("sim_count", 32'(seen_grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            e = '0; e[i] = 1'b1;
            check_eq("sim_order", 32'((i < seen_grants.size()) ? seen_grants[i] : 4'h0), 32'(e));
        end
        check_eq("sim_pending", 32'(bus.pending), 32'h0);

        // fairness: after requester 1, requesters 0 and 2 together -> 2 first
        do_reset();
        tick(4'b0010, BYTES);
        idle_ticks(15, BYTES);
        seen_grants.delete();
        tick(4'b0101, BYTES);
        idle_ticks(30, BYTES);
        check_eq("fair_first",  32'((seen_grants.size() > 0) ? seen_grants[0] : 4'h0), 32'h4);
        check_eq("fair_second", 32'((seen_grants.size() > 1) ? seen_grants[1] : 4'h0), 32'h1);

        // timeout with no busy, then retry succeeds
        do_reset();
        stub_off = 1'b1;
        tick(4'b1000, BYTES);
        idle_ticks(T + 6, BYTES);
        stub_off = 1'b0;
        idle_ticks(25, BYTES);
        check_eq("tmo_retries", 32'(seen_grants.size() >= 2), 32'd1);

        // reset in the middle of a frame with 0 and 1 pending
        do_reset();
        stub_fix_d = 0; stub_fix_len = 12;
        tick(4'b0100, BYTES);
        idle_ticks(4, BYTES);
        tick(4'b0011, BYTES);
        tick('0, BYTES);
        check_eq("mid_pending", 32'(bus.pending), 32'h3);
        do_reset();
        idle_ticks(10, BYTES);
        check_eq("post_rst_starts", 32'(seen_grants.size()), 32'd0);
        tick(4'b0001, BYTES);
        idle_ticks(3, BYTES);
        check_eq("post_rst_honour", 32'(seen_grants.size()), 32'd1);

        // re-press of requester 0 on its grant edge
        do_reset();
        stub_fix_d = 1; stub_fix_len = 2;
        tick(4'b0001, BYTES);
        tick(4'b0001, BYTES);
        check_eq("repress_pend", 32'(bus.pending), 32'h1);
        idle_ticks(25, BYTES);
        check_eq("repress_count", 32'(seen_grants.size()), 32'd2);

        // random traffic
        stub_fix_d = -1; stub_fix_len = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rp;
            for (int b = 0; b < N; b++) rp[b] = ($urandom_range(0, 7) == 0);
            tick(rp, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
